falling_object_engine: RTL
==========================

# falling_object_engine

Parametrised obstacle engine for the dodge game. It holds N_OBJ independently paced falling objects, draws them into the VGA pixel stream, and checks each one against the player rectangle supplied by the player-sprite block. It latches which object caused the failure and counts dodged objects. It sits between the VGA timing generator and the colour mux, and replaces fixed single-object drawing with an enable mask, per-object speed, a run/fail state machine and a colour mode.

## Interface
- N_OBJ, 4: number of object channels (1–16)
- COL_BASE, 100: left column of object 0
- COL_STRIDE, 120: column spacing; object i left column = COL_BASE + i·COL_STRIDE
- OBJ_W, 30 / OBJ_H, 80: object width / height in pixels
- SCREEN_H, 480: visible rows; wrap threshold
- DY, 8: rows moved per object step
- DIV_BASE, 1: object i steps once every DIV_BASE+i frame ticks
- ROW_STAGGER, 40: initial top row of object i = i·ROW_STAGGER; must be < SCREEN_H
- PLAYER_ROW, 400 / PLAYER_H, 40 / PLAYER_W, 30: player rectangle top row, height, width
- VGA_CLK  in  1  sole clock (pixel clock)
- reset  in  1  asynchronous, active-high
- start  in  1  level/pulse; IDLE→RUN
- gameover  in  1  level; forces IDLE; priority over start
- frame_tick  in  1  one-cycle pulse per frame
- enable  in  N_OBJ  per-object channel enable
- player_col  in  11  player left column
- ready  in  1  display-active qualifier
- column_addr, row_addr  in  11 each  current pixel
- red, green, blue  out  1 each  registered pixel colour
- fail_out  out  1  high in FAIL state
- fail_vec  out  N_OBJ  sticky per-object collision flags
- dodged  out  16  count of objects that wrapped during RUN, saturating at 0xFFFF

## Operation
- States: IDLE, RUN, FAIL. Reset → IDLE.
- IDLE: object rows are held at their initial values; tick dividers are 0; no movement and no collision checks. Objects are drawn white. start=1 with gameover=0 → RUN. dodged and fail_vec clear on that transition.
- RUN: on frame_tick, each enabled object increments its divider. When the divider reaches DIV_BASE+i−1, the divider returns to 0 and the object steps.
  - Step: if y+DY ≥ SCREEN_H, then y←0 and dodged increments (saturating); else y←y+DY.
  - All arithmetic is 11-bit unsigned, with a 12-bit intermediate for y+DY.
- Collision for object i: enabled AND col overlap (cb_i < player_col+PLAYER_W AND player_col < cb_i+OBJ_W) AND row overlap (y_i < PLAYER_ROW+PLAYER_H AND PLAYER_ROW < y_i+OBJ_H). It is evaluated every RUN cycle on current positions.
- Any collision → FAIL; fail_vec ORs in every colliding object that cycle.
- FAIL: positions, dividers and dodged are frozen. Objects are drawn red only (green=blue=0). start is ignored. Only gameover or reset leave FAIL.
- gameover=1 in any state → IDLE next edge, with positions and dividers restored to initial values. fail_vec and dodged hold until the next start.
- Disabled objects: not drawn, never collide, divider and position frozen.
- Drawing: pixel is inside object i when enabled and cb_i ≤ column_addr < cb_i+OBJ_W and y_i ≤ row_addr < y_i+OBJ_H.
  - RUN/IDLE hit → white.
  - FAIL hit → red.
  - No hit or ready=0 → black.
  - Overlapping objects are simply ORed.

## Timing
- Reset values: red=green=blue=0, fail_out=0, fail_vec=0, dodged=0, state IDLE, y_i=i·ROW_STAGGER, dividers 0.
- Pixel path: one-cycle latency from column_addr/row_addr/ready to red/green/blue.
- Position update takes effect on the edge where frame_tick=1 is sampled. The collision check on the new position happens the following cycle, so fail_out rises 2 edges after the moving tick.
- Same-cycle collision and frame_tick in RUN: the transition to FAIL wins and no step occurs.
- gameover and start both high: gameover wins.
- Reset asserted mid-RUN or mid-FAIL: all state returns to reset values immediately, independent of clock.

## Test plan
- Reset, ready=1, pixel (105,10) → red=green=blue=1 one cycle later; pixel (135,10) → 0; pixel (105,10) with ready=0 → 0.
- start, player_col=600, 1 frame_tick → y0=8, y1=40; 2nd tick → y0=16, y1=48; 3rd tick → y2=88.
- player_col=600, 60 ticks in RUN → y0 wraps 472→0 on tick 60, dodged=1, fail_out stays 0.
- player_col=100 → after tick 41, y0=328 and fail_out=1, fail_vec=4'b0001 two edges later. Further ticks leave y0=328. Pixel (105,330) → red=1, green=blue=0.
- enable=4'b1110, player_col=100, 100 ticks → no fail. Pixel (105,y) always black.
- gameover during FAIL → IDLE, rows 0/40/80/120, fail_out=0, fail_vec held. Then start → fail_vec=0, dodged=0. Async reset mid-RUN → all outputs 0 without a clock edge.

Source files
------------

// File: rtl/falling_object_engine.sv
// Falling-obstacle engine: N_OBJ independently paced objects drawn into the VGA
// stream, checked against the player rectangle, with an IDLE/RUN/FAIL game FSM.

module falling_object_lane #(
    parameter int IDX        = 0,
    parameter int COL_BASE   = 100,
    parameter int COL_STRIDE = 120,
    parameter int OBJ_W      = 30,
    parameter int OBJ_H      = 80,
    parameter int SCREEN_H   = 480,
    parameter int DY         = 8,
    parameter int DIV_BASE   = 1,
    parameter int PLAYER_ROW = 400,
    parameter int PLAYER_H   = 40,
    parameter int PLAYER_W   = 30
) (
    input  logic        en_i,
    input  logic [10:0] y_i,
    input  logic [7:0]  div_i,
    input  logic [10:0] player_col_i,
    input  logic [10:0] col_i,
    input  logic [10:0] row_i,
    output logic        hit_o,
    output logic        coll_o,
    output logic        term_o,
    output logic        wrap_o,
    output logic [10:0] y_step_o
);
    localparam logic [10:0] CB   = 11'(COL_BASE + IDX * COL_STRIDE);
    localparam logic [10:0] W    = 11'(OBJ_W);
    localparam logic [10:0] H    = 11'(OBJ_H);
    localparam logic [10:0] PR   = 11'(PLAYER_ROW);
    localparam logic [10:0] PH   = 11'(PLAYER_H);
    localparam logic [10:0] PW   = 11'(PLAYER_W);
    localparam logic [7:0]  TERM = 8'(DIV_BASE + IDX - 1);

    logic [11:0] sum;
    assign sum      = {1'b0, y_i} + 12'(DY);
    assign wrap_o   = sum >= 12'(SCREEN_H);
    assign y_step_o = wrap_o ? 11'd0 : sum[10:0];
    assign term_o   = div_i == TERM;

    assign hit_o  = en_i && (col_i >= CB) && (col_i < CB + W)
                         && (row_i >= y_i) && (row_i < y_i + H);
    assign coll_o = en_i && (CB < player_col_i + PW) && (player_col_i < CB + W)
                         && (y_i < PR + PH) && (PR < y_i + H);
endmodule

module falling_object_engine #(
    parameter int N_OBJ       = 4,
    parameter int COL_BASE    = 100,
    parameter int COL_STRIDE  = 120,
    parameter int OBJ_W       = 30,
    parameter int OBJ_H       = 80,
    parameter int SCREEN_H    = 480,
    parameter int DY          = 8,
    parameter int DIV_BASE    = 1,
    parameter int ROW_STAGGER = 40,
    parameter int PLAYER_ROW  = 400,
    parameter int PLAYER_H    = 40,
    parameter int PLAYER_W    = 30
) (
    input  logic             VGA_CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             gameover,
    input  logic             frame_tick,
    input  logic [N_OBJ-1:0] enable,
    input  logic [10:0]      player_col,
    input  logic             ready,
    input  logic [10:0]      column_addr,
    input  logic [10:0]      row_addr,
    output logic             red,
    output logic             green,
    output logic             blue,
    output logic             fail_out,
    output logic [N_OBJ-1:0] fail_vec,
    output logic [15:0]      dodged
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAIL} state_t;

    state_t                  state_q;
    logic [N_OBJ-1:0][10:0]  y_q;
    logic [N_OBJ-1:0][7:0]   div_q;
    logic [N_OBJ-1:0]        fail_vec_q;
    logic [15:0]             dodged_q, dodged_d;
    logic                    fail_q, red_q, green_q, blue_q;

    logic [N_OBJ-1:0]        hit, coll, term, wrap;
    logic [N_OBJ-1:0][10:0]  y_step;

    for (genvar g = 0; g < N_OBJ; g++) begin : g_lane
        falling_object_lane #(
            .IDX(g), .COL_BASE(COL_BASE), .COL_STRIDE(COL_STRIDE),
            .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .SCREEN_H(SCREEN_H), .DY(DY),
            .DIV_BASE(DIV_BASE), .PLAYER_ROW(PLAYER_ROW),
            .PLAYER_H(PLAYER_H), .PLAYER_W(PLAYER_W)
        ) u_lane (
            .en_i(enable[g]), .y_i(y_q[g]), .div_i(div_q[g]),
            .player_col_i(player_col), .col_i(column_addr), .row_i(row_addr),
            .hit_o(hit[g]), .coll_o(coll[g]), .term_o(term[g]),
            .wrap_o(wrap[g]), .y_step_o(y_step[g])
        );
    end

    // Several objects may wrap on the same tick; each one counts.
    logic [4:0]  n_wrap;
    logic [16:0] dodged_sum;
    always_comb begin
        n_wrap = '0;
        for (int i = 0; i < N_OBJ; i++)
            if (enable[i] && term[i] && wrap[i]) n_wrap = n_wrap + 5'd1;
        dodged_sum = {1'b0, dodged_q} + 17'(n_wrap);
        dodged_d   = dodged_sum[16] ? 16'hFFFF : dodged_sum[15:0];
    end

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fail_q     <= 1'b0;
            fail_vec_q <= '0;
            dodged_q   <= '0;
            red_q      <= 1'b0;
            green_q    <= 1'b0;
            blue_q     <= 1'b0;
            for (int i = 0; i < N_OBJ; i++) begin
                y_q[i]   <= 11'(i * ROW_STAGGER);
                div_q[i] <= '0;
            end
        end else begin
            red_q   <= ready && (|hit);
            green_q <= ready && (|hit) && (state_q != S_FAIL);
            blue_q  <= ready && (|hit) && (state_q != S_FAIL);
            if (gameover || state_q == S_IDLE) begin
                for (int i = 0; i < N_OBJ; i++) begin
                    y_q[i]   <= 11'(i * ROW_STAGGER);
                    div_q[i] <= '0;
                end
            end
            if (gameover) begin
                state_q <= S_IDLE;
                fail_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (start) begin
                        state_q    <= S_RUN;
                        fail_vec_q <= '0;
                        dodged_q   <= '0;
                    end
                    S_RUN: if (|coll) begin
                        // Collision beats a same-cycle frame tick.
                        state_q    <= S_FAIL;
                        fail_q     <= 1'b1;
                        fail_vec_q <= fail_vec_q | coll;
                    end else if (frame_tick) begin
                        dodged_q <= dodged_d;
                        for (int i = 0; i < N_OBJ; i++) begin
                            if (enable[i]) begin
                                if (term[i]) begin
                                    div_q[i] <= '0;
                                    y_q[i]   <= y_step[i];
                                end else begin
                                    div_q[i] <= div_q[i] + 8'd1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign red      = red_q;
    assign green    = green_q;
    assign blue     = blue_q;
    assign fail_out = fail_q;
    assign fail_vec = fail_vec_q;
    assign dodged   = dodged_q;
endmodule
